// File: rtl/fetch_stage_if.sv
// I-cache request/response bus between the fetch stage (master) and the cache (slave).
interface fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] data;

    modport master (output req, addr, input ready, data);
    modport slave  (input req, addr, output ready, data);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, I-cache miss FSM with one-entry hold buffer, fetch/decode register.
// Optional RUN->MISS counter enabled by defining FETCH_MISS_CNT_EN.
module fetch_stage #(
    parameter logic [31:0] ResetPc  = 32'h0000_1000,
    parameter logic [31:0] NopInstr = 32'h0000_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_reg_i,
    input  logic                 flush_i,
    input  logic                 branch_taken_i,
    input  logic [31:0]          branch_target_i,
    fetch_stage_if.master        icache,
    output logic [31:0]          instruction_o,
    output logic [31:0]          pcnext_o,
    output logic                 instr_valid_o,
`ifdef FETCH_MISS_CNT_EN
    output logic [31:0]          miss_count_o,
`endif
    output logic                 block_pipe_instr_cache_o
);

    typedef enum logic [1:0] {StRun, StMiss, StHold, StDrain} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_q, redir_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcnext_q, pcnext_d;
    logic        valid_q, valid_d;
    logic        req_en_q;
    logic [31:0] pc_inc;
    logic [31:0] target;
    logic        latch;
    logic [31:0] latch_word;

    assign pc_inc = pc_q + 32'd4;
    assign target = {branch_target_i[31:2], 2'b00};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redir_d    = redir_q;
        hold_d     = hold_q;
        instr_d    = instr_q;
        pcnext_d   = pcnext_q;
        valid_d    = valid_q;
        latch      = 1'b0;
        latch_word = icache.data;

        unique case (state_q)
            StRun: begin
                // req_en_q keeps the first cycle after reset release request-free
                if (req_en_q) begin
                    if (!icache.ready) begin
                        state_d = StMiss;
                    end else if (en_reg_i) begin
                        latch = 1'b1;
                        pc_d  = pc_inc;
                    end
                end
            end
            StMiss: begin
                if (icache.ready) begin
                    if (en_reg_i) begin
                        latch   = 1'b1;
                        pc_d    = pc_inc;
                        state_d = StRun;
                    end else begin
                        hold_d  = icache.data;
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (en_reg_i) begin
                    latch      = 1'b1;
                    latch_word = hold_q;
                    pc_d       = pc_inc;
                    state_d    = StRun;
                end
            end
            StDrain: begin
                if (icache.ready) begin
                    pc_d    = redir_q;
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase

        // A redirect during a miss keeps the old address on the bus until the response drains.
        if (branch_taken_i) begin
            latch = 1'b0;
            if (state_q == StMiss) begin
                pc_d    = pc_q;
                redir_d = target;
                state_d = StDrain;
            end else begin
                pc_d    = target;
                state_d = StRun;
            end
        end

        if (flush_i) begin
            instr_d  = NopInstr;
            pcnext_d = 32'h0;
            valid_d  = 1'b0;
        end else if (latch) begin
            instr_d  = latch_word;
            pcnext_d = pc_inc;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StRun;
            pc_q     <= ResetPc;
            redir_q  <= 32'h0;
            hold_q   <= 32'h0;
            instr_q  <= NopInstr;
            pcnext_q <= 32'h0;
            valid_q  <= 1'b0;
            req_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            redir_q  <= redir_d;
            hold_q   <= hold_d;
            instr_q  <= instr_d;
            pcnext_q <= pcnext_d;
            valid_q  <= valid_d;
            req_en_q <= 1'b1;
        end
    end

`ifdef FETCH_MISS_CNT_EN
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (state_q == StRun && state_d == StMiss && miss_cnt_q != 32'hFFFF_FFFF) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            miss_cnt_q <= 32'h0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign miss_count_o = miss_cnt_q;
`endif

    assign icache.req                = req_en_q && (state_q != StHold);
    assign icache.addr               = pc_q;
    assign instruction_o             = instr_q;
    assign pcnext_o                  = pcnext_q;
    assign instr_valid_o             = valid_q;
    assign block_pipe_instr_cache_o  = (state_q == StMiss) || (state_q == StDrain);

endmodule
